// File: rtl/rvcpu_mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, requester IDs
// and the fixed-priority-with-alternation pick used when both ports request.
package rvcpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MEM_I = 2'd1,
    ST_MEM_D = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Data wins by default; after a data grant a waiting fetch goes first.
  function automatic req_id_e arb_pick(input logic i_req, input logic d_req, input req_id_e last);
    req_id_e win;
    win = REQ_I;
    if (d_req && (!i_req || (last == REQ_I))) begin
      win = REQ_D;
    end
    return win;
  endfunction

endpackage

// File: rtl/rvcpu_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single request/ack memory port.
// Grant one cycle after request in IDLE, rvalid one cycle after m_ack, then back to IDLE.
module rvcpu_mem_arbiter
  import rvcpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                halt,
  output logic                busy
);

  state_e                state_q;
  req_id_e               last_q;
  req_id_e               win_d;
  logic                  m_req_q;
  logic                  m_we_q;
  logic [DATA_W/8-1:0]   m_be_q;
  logic [ADDR_W-1:0]     m_addr_q;
  logic [DATA_W-1:0]     m_wdata_q;
  logic                  i_gnt_q;
  logic                  d_gnt_q;
  logic                  i_rvalid_q;
  logic                  d_rvalid_q;
  logic [DATA_W-1:0]     i_rdata_q;
  logic [DATA_W-1:0]     d_rdata_q;

  assign win_d = arb_pick(i_req, d_req, last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= REQ_I;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!halt && (i_req || d_req)) begin
            m_req_q <= 1'b1;
            last_q  <= win_d;
            if (win_d == REQ_D) begin
              m_we_q    <= d_we;
              m_be_q    <= d_be;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
              d_gnt_q   <= 1'b1;
              state_q   <= ST_MEM_D;
            end else begin
              m_we_q    <= 1'b0;
              m_be_q    <= '1;
              m_addr_q  <= i_addr;
              m_wdata_q <= '0;
              i_gnt_q   <= 1'b1;
              state_q   <= ST_MEM_I;
            end
          end
        end
        ST_MEM_I: begin
          if (m_ack) begin
            i_rdata_q  <= m_rdata;
            i_rvalid_q <= 1'b1;
            m_req_q    <= 1'b0;
            state_q    <= ST_RESP;
          end
        end
        ST_MEM_D: begin
          if (m_ack) begin
            // Stores report completion with zero data rather than whatever the bus returned.
            d_rdata_q  <= m_we_q ? '0 : m_rdata;
            d_rvalid_q <= 1'b1;
            m_req_q    <= 1'b0;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_be     = m_be_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
